// File: rtl/dma_reg_pkg.sv
// Shared definitions for the register-bus DMA master: FSM encoding,
// legal register window and response flag layout.
package dma_reg_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ISSUE   = 2'd1;
    localparam state_t ST_RD_WAIT = 2'd2;
    localparam state_t ST_RESP    = 2'd3;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h400;
    localparam int          DEFAULT_NUM_REGS  = 4;
    localparam int          REG_STRIDE        = 4;

    typedef struct packed {
        logic write;
        logic err;
    } rsp_flags_t;

    // Registers are word aligned and occupy [base, base + stride*num_regs).
    function automatic logic addr_legal(input logic [63:0] addr,
                                        input logic [63:0] base,
                                        input int          num_regs);
        logic [63:0] limit;
        limit = base + 64'(num_regs) * 64'(REG_STRIDE);
        return (addr >= base) && (addr < limit) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/dma_cmd_fifo.sv
// Synchronous command FIFO; the ready flag is registered so the
// upstream handshake is driven straight from a flop.
module dma_cmd_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             not_full
);
    localparam int PW = $clog2(DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;

    logic [WIDTH-1:0] mem [DEPTH];
    ptr_t             wr_ptr;
    ptr_t             rd_ptr;
    cnt_t             count;
    cnt_t             count_next;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_push = push && not_full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_next = count + cnt_t'(do_push) - cnt_t'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers are exactly PW bits wide, so they wrap modulo DEPTH on overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            not_full <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ptr_t'(1);
            count    <= count_next;
            not_full <= (count_next < cnt_t'(DEPTH));
        end
    end

endmodule

// File: rtl/dma_reg_master.sv
// Queues register read/write commands and executes them one at a time on
// a simple valid-strobe register bus, returning one response per command.
module dma_reg_master
    import dma_reg_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(DEFAULT_BASE_ADDR),
    parameter int                    NUM_REGS   = DEFAULT_NUM_REGS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic                  bus_wr_en,
    output logic                  bus_valid,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  busy,
    output logic [1:0]            dbg_state
);
    localparam int CMD_W = 1 + ADDR_WIDTH + DATA_WIDTH;

    // Handshakes: a transfer happens on the rising clk edge where valid and
    // ready are both high; valid and its payload hold until that edge.

    state_t                state;
    logic [CMD_W-1:0]      head;
    logic                  head_write;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_wdata;
    logic                  head_legal;
    logic                  fifo_empty;
    logic                  fifo_pop;
    rsp_flags_t            flags;

    assign {head_write, head_addr, head_wdata} = head;
    assign head_legal = addr_legal(64'(head_addr), 64'(BASE_ADDR), NUM_REGS);
    assign fifo_pop   = (state == ST_IDLE) && !fifo_empty;
    assign busy       = (state != ST_IDLE) || !fifo_empty;
    assign dbg_state  = state;
    assign rsp_write  = flags.write;
    assign rsp_err    = flags.err;

    dma_cmd_fifo #(
        .WIDTH(CMD_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (cmd_valid),
        .wdata   ({cmd_write, cmd_addr, cmd_wdata}),
        .pop     (fifo_pop),
        .rdata   (head),
        .empty   (fifo_empty),
        .not_full(cmd_ready)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            bus_valid <= 1'b0;
            bus_wr_en <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rsp_valid <= 1'b0;
            flags     <= '0;
            rsp_rdata <= '0;
        end else begin
            bus_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        if (head_legal) begin
                            bus_valid <= 1'b1;
                            bus_addr  <= head_addr;
                            bus_wr_en <= head_write;
                            bus_wdata <= head_write ? head_wdata : '0;
                            state     <= ST_ISSUE;
                        end else begin
                            rsp_valid <= 1'b1;
                            flags     <= '{write: head_write, err: 1'b1};
                            rsp_rdata <= '0;
                            state     <= ST_RESP;
                        end
                    end
                end
                // bus_wr_en still reflects the command just strobed.
                ST_ISSUE: begin
                    if (bus_wr_en) begin
                        rsp_valid <= 1'b1;
                        flags     <= '{write: 1'b1, err: 1'b0};
                        rsp_rdata <= '0;
                        state     <= ST_RESP;
                    end else begin
                        state <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    rsp_valid <= 1'b1;
                    flags     <= '{write: 1'b0, err: 1'b0};
                    rsp_rdata <= bus_rdata;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
